// File: rtl/corr_pkg.sv
// Shared definitions for the correlator transmit scheduler: state encoding,
// default frame header word and dropped-trigger counter width.
package corr_pkg;

   // State encoding, kept as plain values so other blocks can decode them.
   localparam logic [2:0] ENC_IDLE  = 3'd0;
   localparam logic [2:0] ENC_SYNC  = 3'd1;
   localparam logic [2:0] ENC_COUNT = 3'd2;
   localparam logic [2:0] ENC_CHAN  = 3'd3;
   localparam logic [2:0] ENC_DONE  = 3'd4;

   typedef enum logic [2:0] {
      IDLE  = ENC_IDLE,
      SYNC  = ENC_SYNC,
      COUNT = ENC_COUNT,
      CHAN  = ENC_CHAN,
      DONE  = ENC_DONE
   } state_t;

   // Header word that opens every frame.
   localparam logic [31:0] DEF_SYNC_WORD = 32'hA5A5_A5A5;

   // Width of the saturating dropped-trigger counter.
   localparam int DROP_W = 16;

endpackage

// File: rtl/corr_tx_scheduler.sv
// Serialises one correlator frame (sync word, frame number, enabled channel
// words) onto the shared word transmitter using a valid/ready handshake.
// Triggers arriving while a frame is in flight are dropped and counted.
module corr_tx_scheduler
   import corr_pkg::*;
#(
   parameter int          CHANNELS   = 12,
   parameter int          RESOLUTION = 32,
   parameter logic [31:0] SYNC_WORD  = DEF_SYNC_WORD
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           trigger,
   input  logic [CHANNELS*RESOLUTION-1:0] chan_data,
   input  logic [CHANNELS-1:0]            chan_mask,
   output logic [RESOLUTION-1:0]          word_data,
   output logic                           word_valid,
   input  logic                           word_ready,
   output logic                           busy,
   output logic                           frame_done,
   output logic                           overrun,
   output logic [RESOLUTION-1:0]          frame_count,
   output logic [DROP_W-1:0]              dropped_count
);

   localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(CHANNELS - 1);
   // Header word fitted to the word width (truncated or zero-extended).
   localparam logic [RESOLUTION-1:0] SYNC_R   = RESOLUTION'(SYNC_WORD);

   state_t                                 state;
   logic [IDX_W-1:0]                       idx;
   logic [IDX_W-1:0]                       idx_nxt;
   logic [CHANNELS-1:0][RESOLUTION-1:0]    snap_data;
   logic [CHANNELS-1:0]                    snap_mask;

   // Next channel slot; only used while idx is below the last channel.
   always_comb begin
      idx_nxt = idx + IDX_W'(1);
   end

   // Frame sequencer with registered handshake outputs and trigger bookkeeping.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         idx           <= '0;
         snap_data     <= '0;
         snap_mask     <= '0;
         word_data     <= '0;
         word_valid    <= 1'b0;
         busy          <= 1'b0;
         frame_done    <= 1'b0;
         overrun       <= 1'b0;
         frame_count   <= '0;
         dropped_count <= '0;
      end else begin
         frame_done <= 1'b0;
         overrun    <= 1'b0;

         // Any trigger outside IDLE (DONE included) is refused.
         if (trigger && (state != IDLE)) begin
            overrun <= 1'b1;
            if (dropped_count != '1)
               dropped_count <= dropped_count + DROP_W'(1);
         end

         case (state)
            IDLE: begin
               if (trigger) begin
                  snap_data   <= chan_data;
                  snap_mask   <= chan_mask;
                  frame_count <= frame_count + RESOLUTION'(1);
                  word_data   <= SYNC_R;
                  word_valid  <= 1'b1;
                  busy        <= 1'b1;
                  state       <= SYNC;
               end
            end
            SYNC: begin
               // frame_count already holds the post-increment value here.
               if (word_ready) begin
                  word_data <= frame_count;
                  state     <= COUNT;
               end
            end
            COUNT: begin
               if (word_ready) begin
                  idx        <= '0;
                  word_valid <= snap_mask[0];
                  word_data  <= snap_data[0];
                  state      <= CHAN;
               end
            end
            CHAN: begin
               // A slot completes on a transfer, or immediately when masked off
               // (word_valid low means this slot is a one-cycle skip).
               if (!word_valid || word_ready) begin
                  if (idx == LAST_IDX) begin
                     word_valid <= 1'b0;
                     busy       <= 1'b0;
                     frame_done <= 1'b1;
                     state      <= DONE;
                  end else begin
                     idx        <= idx_nxt;
                     word_valid <= snap_mask[idx_nxt];
                     word_data  <= snap_data[idx_nxt];
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               word_valid <= 1'b0;
               busy       <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_corr_tx_scheduler.sv
// Bench for corr_tx_scheduler: random frames checked against a word-list
// model of a frame, plus handshake, overrun, reset and counter-edge cases.
module tb_corr_tx_scheduler;

   localparam int CH  = 12;
   localparam int RES = 32;

   logic              clk = 1'b0;
   logic              reset;
   logic              trigger;
   logic [CH*RES-1:0] chan_data;
   logic [CH-1:0]     chan_mask;
   logic [RES-1:0]    word_data;
   logic              word_valid;
   logic              word_ready;
   logic              busy;
   logic              frame_done;
   logic              overrun;
   logic [RES-1:0]    frame_count;
   logic [15:0]       dropped_count;

   int errors = 0;
   int checks = 0;

   // Model state: frames started and triggers dropped.
   logic [RES-1:0] fc_m;
   logic [15:0]    dc_m;

   corr_tx_scheduler #(.CHANNELS(CH), .RESOLUTION(RES), .SYNC_WORD(32'hA5A5_A5A5)) dut (
      .clk(clk), .reset(reset), .trigger(trigger), .chan_data(chan_data),
      .chan_mask(chan_mask), .word_data(word_data), .word_valid(word_valid),
      .word_ready(word_ready), .busy(busy), .frame_done(frame_done),
      .overrun(overrun), .frame_count(frame_count), .dropped_count(dropped_count)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [CH*RES-1:0] rand_data();
      logic [CH*RES-1:0] d;
      for (int i = 0; i < CH; i++) d[i*RES +: RES] = $urandom();
      return d;
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Runs one frame from IDLE. mode: 0 ready always, 1 ready 1-high/3-low,
   // 2 random ready. drop_cyc: frame cycle at which to pulse an extra trigger
   // (-1 none); drop_done: also pulse trigger during the DONE cycle.
   task automatic run_frame(input logic [CH-1:0] mask, input logic [CH*RES-1:0] data,
                            input int mode, input int drop_cyc, input bit drop_done,
                            input string tag);
      logic [RES-1:0] exp_q[$];
      logic [RES-1:0] got_q[$];
      int             cyc;
      bit             done;
      bit             pend;
      bit             exp_ovr;
      logic [RES-1:0] pend_d;
      int             n;

      chan_mask = mask;
      chan_data = data;
      trigger   = 1'b1;
      step();
      trigger = 1'b0;
      fc_m    = fc_m + 1;

      // A frame is: header, frame number, then enabled channels in order.
      exp_q.push_back(32'hA5A5_A5A5);
      exp_q.push_back(fc_m);
      for (int i = 0; i < CH; i++)
         if (mask[i]) exp_q.push_back(data[i*RES +: RES]);

      // Disturb the inputs; the snapshot must be unaffected.
      chan_data = rand_data();
      chan_mask = ~mask;

      cyc = 1; done = 0; pend = 0; exp_ovr = 0; pend_d = '0;
      while (!done && cyc <= 400) begin
         checks++;
         if (overrun !== exp_ovr) begin
            errors++; $display("FAIL %s overrun cyc %0d: got %b want %b", tag, cyc, overrun, exp_ovr);
         end
         exp_ovr = 0;
         if (frame_done === 1'b1) begin
            done = 1;
            checks++;
            if (busy !== 1'b0) begin
               errors++; $display("FAIL %s busy_at_done: got %b want 0", tag, busy);
            end
            if (mode == 0) begin
               checks++;
               if (cyc != 15) begin
                  errors++; $display("FAIL %s done_latency: got %0d want 15", tag, cyc);
               end
            end
         end else begin
            checks++;
            if (busy !== 1'b1) begin
               errors++; $display("FAIL %s busy cyc %0d: got %b want 1", tag, cyc, busy);
            end
            if (pend) begin
               checks++;
               if (word_valid !== 1'b1 || word_data !== pend_d) begin
                  errors++;
                  $display("FAIL %s hold cyc %0d: got v=%b d=%h want v=1 d=%h", tag, cyc, word_valid, word_data, pend_d);
               end
            end
            case (mode)
               0:       word_ready = 1'b1;
               1:       word_ready = (cyc % 4 == 1);
               default: word_ready = 1'($urandom_range(0, 1));
            endcase
            if (word_valid === 1'b1 && word_ready) got_q.push_back(word_data);
            pend   = (word_valid === 1'b1) && !word_ready;
            pend_d = word_data;
            if (cyc == drop_cyc) begin
               trigger = 1'b1;
               exp_ovr = 1;
               dc_m    = sat_inc(dc_m);
            end
            step();
            trigger = 1'b0;
            cyc++;
         end
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL %s timeout: got no frame_done want frame_done within 400 cycles", tag);
      end

      // Now in the DONE cycle.
      if (drop_done) begin
         trigger = 1'b1;
         dc_m    = sat_inc(dc_m);
      end
      step();
      trigger = 1'b0;
      checks++;
      if (overrun !== drop_done) begin
         errors++; $display("FAIL %s overrun_after_done: got %b want %b", tag, overrun, drop_done);
      end
      checks++;
      if (frame_done !== 1'b0 || busy !== 1'b0 || word_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s idle_after_done: got fd=%b busy=%b v=%b want 0 0 0", tag, frame_done, busy, word_valid);
      end

      checks++;
      if (got_q.size() != exp_q.size()) begin
         errors++; $display("FAIL %s word_count: got %0d want %0d", tag, got_q.size(), exp_q.size());
      end
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL %s word[%0d]: got %h want %h", tag, i, got_q[i], exp_q[i]);
         end
      end
      checks++;
      if (frame_count !== fc_m) begin
         errors++; $display("FAIL %s frame_count: got %h want %h", tag, frame_count, fc_m);
      end
      checks++;
      if (dropped_count !== dc_m) begin
         errors++; $display("FAIL %s dropped_count: got %h want %h", tag, dropped_count, dc_m);
      end
      word_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; trigger = 1'b0; word_ready = 1'b0;
      chan_data = '0; chan_mask = '0;
      repeat (3) step();
      checks++;
      if (word_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 || overrun !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: got v=%b busy=%b fd=%b ov=%b want all 0", word_valid, busy, frame_done, overrun);
      end
      checks++;
      if (word_data !== '0 || frame_count !== '0 || dropped_count !== '0) begin
         errors++;
         $display("FAIL reset_values: got d=%h fc=%h dc=%h want 0", word_data, frame_count, dropped_count);
      end
      reset = 1'b0;
      fc_m = '0; dc_m = '0;
      step();
   endtask

   task automatic test_full_frame();
      logic [CH*RES-1:0] d;
      for (int i = 0; i < CH; i++) d[i*RES +: RES] = 32'h1000_0000 + i;
      run_frame(12'hFFF, d, 0, -1, 1'b0, "full_frame");
   endtask

   task automatic test_sparse_slow_ready();
      run_frame(12'h005, rand_data(), 1, -1, 1'b0, "sparse_slow");
   endtask

   task automatic test_overrun();
      run_frame(12'hFFF, rand_data(), 0, 3, 1'b1, "overrun");
   endtask

   task automatic test_empty_mask();
      run_frame(12'h000, rand_data(), 0, -1, 1'b0, "empty_mask");
   endtask

   task automatic test_random();
      for (int k = 0; k < 8; k++) begin
         run_frame(12'($urandom()), rand_data(), 2,
                   ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 12)) : -1,
                   1'($urandom_range(0, 1)), "random");
         repeat ($urandom_range(0, 3)) step();
      end
   endtask

   task automatic test_drop_saturate();
      force dut.dropped_count = 16'hFFFF;
      step();
      release dut.dropped_count;
      step();
      dc_m = 16'hFFFF;
      checks++;
      if (dropped_count !== 16'hFFFF) begin
         errors++; $display("FAIL drop_preload: got %h want ffff", dropped_count);
      end
      run_frame(12'hA5A, rand_data(), 0, 2, 1'b0, "drop_saturate");
   endtask

   task automatic test_count_wrap();
      force dut.frame_count = 32'hFFFF_FFFF;
      step();
      release dut.frame_count;
      step();
      fc_m = 32'hFFFF_FFFF;
      checks++;
      if (frame_count !== 32'hFFFF_FFFF) begin
         errors++; $display("FAIL count_preload: got %h want ffffffff", frame_count);
      end
      run_frame(12'h0F0, rand_data(), 0, -1, 1'b0, "count_wrap");
   endtask

   task automatic test_reset_midframe();
      chan_mask  = 12'hFFF;
      chan_data  = rand_data();
      word_ready = 1'b1;
      trigger    = 1'b1;
      step();
      trigger = 1'b0;
      repeat (4) step();
      checks++;
      if (word_valid !== 1'b1 || busy !== 1'b1) begin
         errors++; $display("FAIL midframe_pre: got v=%b busy=%b want 1 1", word_valid, busy);
      end
      reset = 1'b1;
      step();
      checks++;
      if (word_valid !== 1'b0 || busy !== 1'b0 || frame_count !== '0 || dropped_count !== '0) begin
         errors++;
         $display("FAIL midframe_reset: got v=%b busy=%b fc=%h dc=%h want 0 0 0 0",
                  word_valid, busy, frame_count, dropped_count);
      end
      reset = 1'b0; word_ready = 1'b0;
      fc_m = '0; dc_m = '0;
      step();
      run_frame(12'h3C3, rand_data(), 0, -1, 1'b0, "after_reset");
   endtask

   initial begin
      reset = 1'b1; trigger = 1'b0; word_ready = 1'b0;
      chan_data = '0; chan_mask = '0;
      fc_m = '0; dc_m = '0;
      test_reset();
      test_full_frame();
      test_sparse_slow_ready();
      test_overrun();
      test_empty_mask();
      test_random();
      test_drop_saturate();
      test_count_wrap();
      test_reset_midframe();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
